// File: rtl/ball_rest_detector.sv
// Frame-level rest detector: one shared near-zero comparator scans every ball's velocity per start.
// Optional RAM zero-snap of close components is enabled by defining REST_DETECT_ZERO_SNAP_EN.
module ball_rest_detector #(
  parameter int WIDTH         = 32,
  parameter int TOL           = 10,
  parameter int N_BALLS       = 16,
  parameter int IDX_W         = 4,
  parameter int SETTLE_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    vel_rd,
  output logic [IDX_W-1:0]        vel_addr,
  input  logic signed [WIDTH-1:0] vel_x,
  input  logic signed [WIDTH-1:0] vel_y,
  output logic                    vel_wr,
  output logic [1:0]              vel_wmask,
  output logic                    busy,
  output logic                    done,
  output logic [N_BALLS-1:0]      moving_mask,
  output logic                    all_rest,
  output logic                    overrun
);

  typedef enum logic [2:0] {IDLE, FETCH, CMP_X, CMP_Y, FINISH} state_t;

  localparam logic signed [WIDTH:0]   TOL_LIM    = {{WIDTH{1'b0}}, 1'b1} << TOL;
  localparam logic signed [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]              SETTLE_MAX = 8'(SETTLE_FRAMES);
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_BALLS - 1);

  // Sign-extend by one bit so -TOL_LIM never overflows; the most negative code is excluded outright.
  function automatic logic near_zero(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ve;
    ve = {v[WIDTH-1], v};
    return (v != MOST_NEG) && (ve >= -TOL_LIM) && (ve <= TOL_LIM);
  endfunction

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [N_BALLS-1:0]      scratch_r, scratch_s;
  logic                    all_close_r, all_close_s;
  logic                    x_close_r, x_close_s;
  logic signed [WIDTH-1:0] y_r, y_s;
  logic [7:0]              settle_r, settle_s;
  logic [N_BALLS-1:0]      moving_r, moving_s;
  logic                    all_rest_r, all_rest_s;
  logic                    vel_rd_r, vel_rd_s;
  logic [IDX_W-1:0]        vel_addr_r, vel_addr_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    overrun_r, overrun_s;
  logic signed [WIDTH-1:0] cmp_in_s;
  logic                    close_s;
  logic                    ball_close_s;

  // The single comparator sees live x in CMP_X and the latched y in CMP_Y.
  assign cmp_in_s = (state_r == CMP_Y) ? y_r : vel_x;
  assign close_s  = near_zero(cmp_in_s);

  // Next-state, scan datapath and registered-output next values.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    scratch_s    = scratch_r;
    all_close_s  = all_close_r;
    x_close_s    = x_close_r;
    y_s          = y_r;
    settle_s     = settle_r;
    moving_s     = moving_r;
    all_rest_s   = all_rest_r;
    ball_close_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = FETCH;
          idx_s       = {IDX_W{1'b0}};
          scratch_s   = {N_BALLS{1'b0}};
          all_close_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: state_s = CMP_X;
      CMP_X: begin
        x_close_s = close_s;
        y_s       = vel_y;
        state_s   = CMP_Y;
      end
      CMP_Y: begin
        ball_close_s      = x_close_r & close_s;
        scratch_s[idx_r]  = ~ball_close_s;
        all_close_s       = all_close_r & ball_close_s;
        if (idx_r == LAST_IDX) begin
          state_s = FINISH;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = FETCH;
        end
      end
      FINISH: begin
        moving_s = scratch_r;
        if (all_close_r) begin
          if (settle_r == SETTLE_MAX) begin
            settle_s = settle_r;
          end else begin
            settle_s = settle_r + 8'd1;
          end
        end else begin
          settle_s = 8'd0;
        end
        all_rest_s = (settle_s == SETTLE_MAX);
        state_s    = IDLE;
      end
      default: state_s = IDLE;
    endcase

    vel_rd_s = (state_s == FETCH);
    if (state_s == FETCH || state_s == CMP_X || state_s == CMP_Y) begin
      vel_addr_s = idx_s;
    end else begin
      vel_addr_s = {IDX_W{1'b0}};
    end
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == FINISH);
    overrun_s = start && (state_r != IDLE);
  end

  // State, scan datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      scratch_r   <= {N_BALLS{1'b0}};
      all_close_r <= 1'b0;
      x_close_r   <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      settle_r    <= 8'd0;
      moving_r    <= {N_BALLS{1'b1}};
      all_rest_r  <= 1'b0;
      vel_rd_r    <= 1'b0;
      vel_addr_r  <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      scratch_r   <= scratch_s;
      all_close_r <= all_close_s;
      x_close_r   <= x_close_s;
      y_r         <= y_s;
      settle_r    <= settle_s;
      moving_r    <= moving_s;
      all_rest_r  <= all_rest_s;
      vel_rd_r    <= vel_rd_s;
      vel_addr_r  <= vel_addr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      overrun_r   <= overrun_s;
    end
  end

  assign vel_rd      = vel_rd_r;
  assign vel_addr    = vel_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign moving_mask = moving_r;
  assign all_rest    = all_rest_r;
  assign overrun     = overrun_r;

`ifdef REST_DETECT_ZERO_SNAP_EN
  // Write strobe depends on the y comparison made in this very cycle, so it comes from registers plus the comparator.
  assign vel_wr    = (state_r == CMP_Y) && (x_close_r || close_s);
  assign vel_wmask = vel_wr ? {close_s, x_close_r} : 2'b00;
`else
  assign vel_wr    = 1'b0;
  assign vel_wmask = 2'b00;
`endif

endmodule

// File: tb/tb_ball_rest_detector.sv
// Self-checking bench for ball_rest_detector: RAM model, cycle-offset reference model, randomized scans.
module tb_ball_rest_detector;

  localparam int NB     = 16;
  localparam int SETTLE = 8;
  localparam int TOLB   = 10;
  localparam int SCAN   = 3 * NB + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               vel_rd;
  logic [3:0]         vel_addr;
  logic signed [31:0] vel_x = 32'sd0;
  logic signed [31:0] vel_y = 32'sd0;
  logic               vel_wr;
  logic [1:0]         vel_wmask;
  logic               busy, done, all_rest, overrun;
  logic [NB-1:0]      moving_mask;

  logic signed [31:0] vx [NB];
  logic signed [31:0] vy [NB];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  ball_rest_detector #(.WIDTH(32), .TOL(TOLB), .N_BALLS(NB), .IDX_W(4), .SETTLE_FRAMES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vel_rd(vel_rd), .vel_addr(vel_addr),
    .vel_x(vel_x), .vel_y(vel_y), .vel_wr(vel_wr), .vel_wmask(vel_wmask), .busy(busy),
    .done(done), .moving_mask(moving_mask), .all_rest(all_rest), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Velocity RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (vel_rd) begin
      vel_x <= vx[vel_addr];
      vel_y <= vy[vel_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_close(input longint v);
    return (v >= -(64'sd1 << TOLB)) && (v <= (64'sd1 << TOLB));
  endfunction

  function automatic logic [NB-1:0] calc_mask();
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b] = !(is_close(longint'(vx[b])) && is_close(longint'(vy[b])));
    end
    return m;
  endfunction

  // Reference model: m_t counts cycles since an accepted start (0 = idle).
  int            m_t = 0;
  int            m_settle = 0;
  logic [NB-1:0] m_mask = '1;
  logic [NB-1:0] m_scan_mask = '0;
  bit            m_ovr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_settle <= 0; m_mask <= '1; m_scan_mask <= '0; m_ovr <= 1'b0;
    end else begin
      m_ovr <= start && (m_t != 0);
      if (m_t == 0) begin
        if (start) begin
          m_t <= 1;
          m_scan_mask <= calc_mask();
        end
      end else if (m_t == SCAN) begin
        m_t <= 0;
        m_mask <= m_scan_mask;
        m_settle <= (m_scan_mask == '0) ? ((m_settle < SETTLE) ? m_settle + 1 : SETTLE) : 0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Compare process: every cycle, 1 time unit after the rising edge.
  always begin
    bit       e_rd, e_wr;
    logic [1:0] e_wm;
    logic [3:0] e_addr;
    int       b;
    @(posedge clk);
    #1;
    if (cmp_en) begin
      e_rd = (m_t >= 1) && (m_t <= 3 * NB) && ((m_t - 1) % 3 == 0);
      e_addr = 4'((m_t - 1) / 3);
      e_wr = 1'b0;
      e_wm = 2'b00;
`ifdef REST_DETECT_ZERO_SNAP_EN
      if (m_t >= 3 && m_t <= 3 * NB && (m_t % 3 == 0)) begin
        b = m_t / 3 - 1;
        e_wm = {is_close(longint'(vy[b])), is_close(longint'(vx[b]))};
        e_wr = (e_wm != 2'b00);
        e_addr = 4'(b);
      end
`else
      b = 0;
`endif
      chk("busy", busy, m_t != 0);
      chk("done", done, m_t == SCAN);
      chk("vel_rd", vel_rd, e_rd);
      if (e_rd || e_wr) chk("vel_addr", vel_addr, e_addr);
      chk("vel_wr", vel_wr, e_wr);
      chk("vel_wmask", vel_wmask, e_wm);
      chk("overrun", overrun, m_ovr);
      chk("moving_mask", moving_mask, m_mask);
      chk("all_rest", all_rest, m_settle == SETTLE);
    end
  end

  // Called 2 units after an edge in an idle cycle; returns in the done cycle.
  task automatic run_scan(input int extra, output int done_at, output int ovr_at);
    done_at = -1;
    ovr_at = -1;
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #2;
      start = (extra != 0) && (n == extra);
      if (overrun && ovr_at < 0) ovr_at = n;
      if (done) begin
        done_at = n;
        break;
      end
    end
    start = 1'b0;
    if (done_at < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic signed [31:0] rnd_v();
    case ($urandom_range(0, 7))
      0: return 32'sd0;
      1: return 32'sd1024;
      2: return -32'sd1024;
      3: return 32'sd1025;
      4: return -32'sd1025;
      5: return 32'sh80000000;
      6: return $signed(32'($urandom_range(0, 2048))) - 32'sd1024;
      default: return $signed($urandom);
    endcase
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #2;
  endtask

  initial begin
    int d, o;
    for (int b = 0; b < NB; b++) begin vx[b] = 32'sd0; vy[b] = 32'sd0; end
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    idle_cycle();
    chk("reset_mask", moving_mask, 16'hffff);
    chk("reset_all_rest", all_rest, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // All balls at rest: all_rest after the 8th scan, not the 7th.
    for (int s = 1; s <= SETTLE; s++) begin
      run_scan(0, d, o);
      chk("rest_done_cycle", d, 49);
      idle_cycle();
      chk("rest_mask", moving_mask, 16'h0000);
      if (s == SETTLE - 1) chk("all_rest_after7", all_rest, 1'b0);
      if (s == SETTLE) chk("all_rest_after8", all_rest, 1'b1);
    end

    // Ball 5 just over tolerance, others on the inclusive bound.
    for (int b = 0; b < NB; b++) begin vx[b] = 32'sd1024; vy[b] = -32'sd1024; end
    vx[5] = 32'sd1025;
    run_scan(0, d, o);
    idle_cycle();
    chk("ball5_mask", moving_mask, 16'h0020);
    chk("ball5_all_rest", all_rest, 1'b0);

    // Most negative code is never close.
    for (int b = 0; b < NB; b++) begin vx[b] = 32'sd0; vy[b] = 32'sd0; end
    vy[0] = 32'sh80000000;
    run_scan(0, d, o);
    idle_cycle();
    chk("minneg_mask", moving_mask, 16'h0001);
    vy[0] = -32'sd1024;
    run_scan(0, d, o);
    idle_cycle();
    chk("neg_bound_mask", moving_mask, 16'h0000);

    // Snap candidate ball 3 and a start pulse mid-scan.
    vx[3] = 32'sd7; vy[3] = 32'sd5000;
    run_scan(10, d, o);
    chk("ovr_cycle", o, 11);
    chk("ovr_done_cycle", d, 49);
    idle_cycle();
    chk("ball3_mask", moving_mask, 16'h0008);
    repeat (5) idle_cycle();
    chk("no_second_scan", busy, 1'b0);

    // Randomized scans, including starts in mid-scan and in the done cycle.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int b = 0; b < NB; b++) begin
          vx[b] = $signed(32'($urandom_range(0, 2048))) - 32'sd1024;
          vy[b] = $signed(32'($urandom_range(0, 2048))) - 32'sd1024;
        end
        if ($urandom_range(0, 3) == 0) vx[$urandom_range(0, NB - 1)] = rnd_v();
      end else begin
        for (int b = 0; b < NB; b++) begin vx[b] = rnd_v(); vy[b] = rnd_v(); end
      end
      run_scan(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 48)) : 0, d, o);
      chk("rand_done_cycle", d, 49);
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
      end else begin
        idle_cycle();
      end
    end

    // Reset mid-scan discards the partial scan.
    run_scan(0, d, o);
    idle_cycle();
    start = 1'b1;
    idle_cycle();
    start = 1'b0;
    repeat (20) idle_cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_rd", vel_rd, 1'b0);
    chk("mid_reset_mask", moving_mask, 16'hffff);
    chk("mid_reset_all_rest", all_rest, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle_cycle();
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_done", done, 1'b0);
    run_scan(0, d, o);
    chk("post_reset_done_cycle", d, 49);
    repeat (3) idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_rest_detector.md
# ball_rest_detector

Frame-level scheduler that shares one signed near-zero comparator (|v| ≤ 2^TOL) across all ball velocity components held in the physics velocity RAM. On each `start` it scans every ball, building a per-ball moving mask. It maintains a settle counter that asserts `all_rest` once every ball has stayed near zero for SETTLE_FRAMES consecutive scans. It sits between the frame sequencer and the velocity RAM; the game FSM uses `all_rest` to end a shot.

## Interface
- WIDTH, 32, signed velocity component width
- TOL, 10, tolerance exponent; a component is close when -2^TOL ≤ v ≤ 2^TOL
- N_BALLS, 16, number of balls scanned (≥1)
- IDX_W, 4, ball index width; 2^IDX_W ≥ N_BALLS
- SETTLE_FRAMES, 8, consecutive all-close scans required (1..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a scan
- vel_rd  out  1  RAM read strobe
- vel_addr  out  IDX_W  ball index being read
- vel_x  in  WIDTH  signed x velocity, valid 1 cycle after vel_rd
- vel_y  in  WIDTH  signed y velocity, valid 1 cycle after vel_rd
- vel_wr  out  1  RAM write strobe (snap feature)
- vel_wmask  out  2  bit0 = zero x, bit1 = zero y (snap feature)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- moving_mask  out  N_BALLS  bit i = 1 if ball i not close in last scan
- all_rest  out  1  settle counter reached SETTLE_FRAMES
- overrun  out  1  one-cycle pulse: start arrived while busy

## Operation
- Exactly one comparator instance; inputs muxed between live vel_x and registered vel_y.
- States: IDLE, FETCH, CMP_X, CMP_Y, FINISH.
- IDLE: on start → FETCH, idx=0, clear scratch mask and all_close flag set to 1.
- FETCH: vel_rd=1, vel_addr=idx → CMP_X.
- CMP_X: compare vel_x; latch vel_y and x result → CMP_Y.
- CMP_Y: compare latched y; ball close = x_close & y_close; scratch mask bit idx = ~close; all_close &= close. If idx = N_BALLS-1 → FINISH else idx+1, → FETCH.
- FINISH: moving_mask ← scratch mask; done=1; if all_close, settle_cnt increments saturating at SETTLE_FRAMES, else settle_cnt=0 → IDLE.
- all_rest = (settle_cnt == SETTLE_FRAMES), registered, updates with moving_mask.
- Compares are signed; bound 2^TOL is inclusive; -2^(WIDTH-1) is never close.
- start while not IDLE: ignored, overrun pulses same cycle +1; current scan unaffected.
- start in the FINISH cycle counts as busy (overrun).

## Timing
- Reset values: vel_rd, vel_addr, vel_wr, vel_wmask, busy, done, overrun = 0; moving_mask = all ones; all_rest = 0; settle_cnt = 0; state IDLE.
- busy = 1 from cycle after start through FINISH inclusive.
- Scan length: 3·N_BALLS + 1 cycles; done asserted cycle 3·N_BALLS+1 after start (N_BALLS=16 → cycle 49).
- RAM read latency fixed at 1 cycle; no back-pressure.
- Reset asserted mid-scan: immediate return to reset values; partial scan discarded.
- Next start accepted in the cycle done is high +1 (i.e. once IDLE).

## Configuration
- REST_DETECT_ZERO_SNAP_EN defined: in CMP_Y, if either component is close, vel_wr=1, vel_addr=idx, vel_wmask={y_close, x_close}; RAM zeroes flagged components (drift removal). Classification unchanged.
- Undefined: vel_wr and vel_wmask tied 0; ports remain present.

## Test plan
- Reset: hold rst_n=0 mid-scan → all outputs at reset values, state IDLE next cycle after release.
- All balls v=(0,0), SETTLE_FRAMES=8, 8 starts → done at cycle 49 each; moving_mask=0; all_rest=1 after 8th done, not 7th.
- Ball 5 x=1025 (2^10+1), others x=1024/y=-1024 → moving_mask=0x0020, settle_cnt=0, all_rest=0.
- Boundary: y=-2^31 on ball 0 → ball 0 moving; y=-1024 → close.
- start pulsed at cycle 10 of a scan → overrun pulse, done still at cycle 49, no second scan.
- With REST_DETECT_ZERO_SNAP_EN: ball 3 = (7, 5000) → vel_wr=1, vel_addr=3, vel_wmask=2'b01 in its CMP_Y cycle; ball 3 moving; without macro vel_wr never 1.
